// File: rtl/limber_gnrl_fifo_wrarb.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ valid/ready requesters.
// Latency: one IDLE cycle from request to grant; then one beat per cycle for up to MAXBURST beats.
// Backpressure: req_ready[owner] follows ~fifo_full; the grant is held while the owner stays valid.
//
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   req_valid/_ready  per-requester handshake; req_data carries requester i in [i*DW +: DW]
//   fifo_din/_wen     drive the FIFO write pins; fifo_full throttles them
//   fifo_ren/_empty   mirrored consumer read strobe and FIFO empty, used only for level
//   gnt_id, busy      current owner (meaningful while busy) and XFER indicator
//   level             FIFO occupancy, 0..2^AW-1
module limber_gnrl_fifo_wrarb #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int MAXBURST = 4,
  parameter int IDW      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [DW-1:0]        fifo_din,
  output logic                 fifo_wen,
  input  logic                 fifo_full,
  input  logic                 fifo_ren,
  input  logic                 fifo_empty,
  output logic [IDW-1:0]       gnt_id,
  output logic                 busy,
  output logic [AW-1:0]        level
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic [7:0]     beat_cnt;

  logic [IDW-1:0] sel_idx;
  logic           sel_vld;
  logic           owner_vld;
  logic           last_beat;
  logic           rd_eff;

  // Index arithmetic modulo NREQ, so non-power-of-two requester counts wrap correctly.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  // Scan from the highest offset down so the requester closest to ptr wins last.
  always_comb begin
    sel_idx = '0;
    sel_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[wrap_add(ptr, i)]) begin
        sel_idx = wrap_add(ptr, i);
        sel_vld = 1'b1;
      end
    end
  end

  assign owner_vld = req_valid[owner];

  always_comb begin
    req_ready = '0;
    fifo_wen  = 1'b0;
    fifo_din  = '0;
    if (state == XFER) begin
      req_ready[owner] = ~fifo_full;
      fifo_wen         = owner_vld & ~fifo_full;
      fifo_din         = req_data[int'(owner)*DW +: DW];
    end
  end

  assign last_beat = fifo_wen && (beat_cnt == 8'(MAXBURST - 1));
  assign rd_eff    = fifo_ren & ~fifo_empty;
  assign busy      = (state == XFER);
  assign gnt_id    = owner;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      level    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            owner    <= sel_idx;
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          // Release on owner dropping valid (even while full) or after the final beat.
          if (!owner_vld || last_beat) begin
            state <= IDLE;
            ptr   <= wrap_add(owner, 1);
          end else if (fifo_wen) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
      endcase

      // A write and an effective read in the same cycle cancel out.
      if (fifo_wen && !rd_eff) begin
        level <= level + 1'b1;
      end else if (!fifo_wen && rd_eff) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_limber_gnrl_fifo_wrarb.sv
module tb_limber_gnrl_fifo_wrarb;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        fifo_ren;

  logic [3:0]  rdy0, rdy1;
  logic [7:0]  din0, din1;
  logic        wen0, wen1;
  logic        full0, full1, empty0, empty1;
  logic [1:0]  gnt0, gnt1;
  logic        busy0, busy1;
  logic [7:0]  lvl0;
  logic [1:0]  lvl1;

  int env_cnt0, env_cnt1;
  int cyc;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign full0  = (env_cnt0 == 255);
  assign empty0 = (env_cnt0 == 0);
  assign full1  = (env_cnt1 == 3);
  assign empty1 = (env_cnt1 == 0);

  limber_gnrl_fifo_wrarb #(.NREQ(4), .DW(8), .AW(8), .MAXBURST(MAXB), .IDW(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(rdy0),
    .fifo_din(din0), .fifo_wen(wen0), .fifo_full(full0), .fifo_ren(fifo_ren),
    .fifo_empty(empty0), .gnt_id(gnt0), .busy(busy0), .level(lvl0)
  );

  limber_gnrl_fifo_wrarb #(.NREQ(4), .DW(8), .AW(2), .MAXBURST(MAXB), .IDW(2)) u_dut_small (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(rdy1),
    .fifo_din(din1), .fifo_wen(wen1), .fifo_full(full1), .fifo_ren(fifo_ren),
    .fifo_empty(empty1), .gnt_id(gnt1), .busy(busy1), .level(lvl1)
  );

  // Stand-in FIFOs: occupancy drives full/empty back into each arbiter.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      env_cnt0 <= 0;
      env_cnt1 <= 0;
    end else begin
      env_cnt0 <= env_cnt0 + (wen0 ? 1 : 0) - ((fifo_ren && !empty0) ? 1 : 0);
      env_cnt1 <= env_cnt1 + (wen1 ? 1 : 0) - ((fifo_ren && !empty1) ? 1 : 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: per instance, grant holder, rotation pointer, beats taken, occupancy.
  int m_busy[2], m_owner[2], m_ptr[2], m_beat[2], m_level[2];
  logic [3:0] a_rdy[2];
  logic [7:0] a_din[2];
  logic [7:0] a_lvl[2];
  logic [1:0] a_gnt[2];
  logic       a_wen[2], a_busy[2], a_full[2], a_empty[2];
  int beat_log[$];
  int gnt_log[$];
  logic prev_busy0 = 1'b0;

  always @(negedge clk) begin
    a_rdy[0] = rdy0;  a_rdy[1] = rdy1;
    a_din[0] = din0;  a_din[1] = din1;
    a_lvl[0] = lvl0;  a_lvl[1] = {6'd0, lvl1};
    a_gnt[0] = gnt0;  a_gnt[1] = gnt1;
    a_wen[0] = wen0;  a_wen[1] = wen1;
    a_busy[0] = busy0; a_busy[1] = busy1;
    a_full[0] = full0; a_full[1] = full1;
    a_empty[0] = empty0; a_empty[1] = empty1;
    for (int k = 0; k < 2; k++) begin
      int e_wen, e_rdy, e_din, rd;
      if (!rst) begin
        m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_beat[k] = 0; m_level[k] = 0;
        chk($sformatf("i%0d reset busy", k), a_busy[k], 0);
        chk($sformatf("i%0d reset ready", k), a_rdy[k], 0);
        chk($sformatf("i%0d reset wen", k), a_wen[k], 0);
        chk($sformatf("i%0d reset din", k), a_din[k], 0);
        chk($sformatf("i%0d reset gnt", k), a_gnt[k], 0);
        chk($sformatf("i%0d reset level", k), a_lvl[k], 0);
      end else begin
        e_wen = (m_busy[k] != 0 && req_valid[m_owner[k]] && !a_full[k]) ? 1 : 0;
        e_rdy = (m_busy[k] != 0 && !a_full[k]) ? (1 << m_owner[k]) : 0;
        e_din = (m_busy[k] != 0) ? int'(req_data[m_owner[k]*8 +: 8]) : 0;
        chk($sformatf("i%0d busy c%0d", k, cyc), a_busy[k], m_busy[k]);
        chk($sformatf("i%0d ready c%0d", k, cyc), a_rdy[k], e_rdy);
        chk($sformatf("i%0d wen c%0d", k, cyc), a_wen[k], e_wen);
        chk($sformatf("i%0d din c%0d", k, cyc), a_din[k], e_din);
        chk($sformatf("i%0d level c%0d", k, cyc), a_lvl[k], m_level[k]);
        if (m_busy[k] != 0) chk($sformatf("i%0d gnt c%0d", k, cyc), a_gnt[k], m_owner[k]);

        rd = (fifo_ren && !a_empty[k]) ? 1 : 0;
        m_level[k] = m_level[k] + e_wen - rd;
        if (m_busy[k] == 0) begin
          if (req_valid != 4'd0) begin
            for (int j = 3; j >= 0; j--)
              if (req_valid[(m_ptr[k] + j) % 4]) m_owner[k] = (m_ptr[k] + j) % 4;
            m_beat[k] = 0;
            m_busy[k] = 1;
          end
        end else if (!req_valid[m_owner[k]] || (e_wen != 0 && m_beat[k] == MAXB - 1)) begin
          m_busy[k] = 0;
          m_ptr[k]  = (m_owner[k] + 1) % 4;
        end else if (e_wen != 0) begin
          m_beat[k] = m_beat[k] + 1;
        end
      end
    end
    if (rst && wen0) beat_log.push_back(int'(gnt0));
    if (rst && busy0 && !prev_busy0) gnt_log.push_back(int'(gnt0));
    prev_busy0 = rst ? busy0 : 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(i * 64 + (cyc % 64));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = 4'd0;
    fifo_ren = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    beat_log.delete();
    gnt_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    req_valid = 4'd0;
    req_data = 32'd0;
    fifo_ren = 1'b0;
    cyc = 0;
    tick();
    tick();
    chk("reset busy", busy0, 0);
    chk("reset level", lvl0, 0);
    chk("reset ready", rdy0, 0);
    chk("reset din", din0, 0);
    chk("reset gnt", gnt0, 0);

    // 1: single requester, four-beat bursts with an idle gap
    rst = 1'b1;
    req_valid = 4'b0001;
    tick(); chk("t1 busy", busy0, 1); chk("t1 gnt", gnt0, 0); chk("t1 lvl0", lvl0, 0);
    tick(); chk("t1 lvl1", lvl0, 1);
    tick(); chk("t1 lvl2", lvl0, 2);
    tick(); chk("t1 lvl3", lvl0, 3);
    tick(); chk("t1 lvl4", lvl0, 4); chk("t1 idle", busy0, 0);
    tick(); chk("t1 regrant", busy0, 1); chk("t1 regrant id", gnt0, 0);

    // 2: all requesting, rotation 0,1,2,3,0 with exactly four beats each
    do_reset();
    req_valid = 4'b1111;
    repeat (25) tick();
    req_valid = 4'd0;
    chk("t2 beats", beat_log.size(), 20);
    for (int j = 0; j < 20 && j < beat_log.size(); j++)
      chk($sformatf("t2 beat%0d", j), beat_log[j], (j / 4) % 4);
    chk("t2 grants", gnt_log.size(), 5);
    for (int j = 0; j < 5 && j < gnt_log.size(); j++)
      chk($sformatf("t2 grant%0d", j), gnt_log[j], j % 4);
    chk("t2 level", lvl0, 20);
    repeat (2) tick();

    // 3: owner 2 drops after two beats; pointer moves to 3 so 3 beats 0
    do_reset();
    req_valid = 4'b1100;
    repeat (3) tick();
    req_valid = 4'b1001;
    tick(); chk("t3 idle", busy0, 0);
    tick(); chk("t3 busy", busy0, 1); chk("t3 gnt", gnt0, 3);
    tick();
    req_valid = 4'd0;
    chk("t3 beats", beat_log.size(), 3);
    if (beat_log.size() == 3) begin
      chk("t3 beat0", beat_log[0], 2);
      chk("t3 beat1", beat_log[1], 2);
      chk("t3 beat2", beat_log[2], 3);
    end
    chk("t3 grants", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("t3 grant0", gnt_log[0], 2);
      chk("t3 grant1", gnt_log[1], 3);
    end
    repeat (2) tick();

    // 4: small FIFO fills at 3, grant held, one read lets the 4th beat in
    do_reset();
    req_valid = 4'b0001;
    repeat (4) tick();
    chk("t4 full level", lvl1, 3); chk("t4 full busy", busy1, 1); chk("t4 full ready", rdy1, 0);
    tick();
    chk("t4 hold level", lvl1, 3); chk("t4 hold busy", busy1, 1);
    fifo_ren = 1'b1;
    tick();
    fifo_ren = 1'b0;
    chk("t4 read level", lvl1, 2); chk("t4 read ready", rdy1, 4'b0001);
    tick();
    chk("t4 refill level", lvl1, 3); chk("t4 done", busy1, 0);
    req_valid = 4'd0;
    repeat (2) tick();

    // 5: write and read together leave level unchanged; read while empty does nothing
    do_reset();
    req_valid = 4'b0001;
    repeat (3) tick();
    chk("t5 pre level", lvl0, 2);
    fifo_ren = 1'b1;
    tick();
    chk("t5 wr+rd level", lvl0, 2);
    fifo_ren = 1'b0;
    req_valid = 4'd0;
    tick();
    chk("t5 post level", lvl0, 2);
    do_reset();
    fifo_ren = 1'b1;
    repeat (2) tick();
    chk("t5 empty level", lvl0, 0);
    chk("t5 empty level small", lvl1, 0);
    fifo_ren = 1'b0;

    // 6: asynchronous reset mid-burst, then arbitration restarts from requester 0
    do_reset();
    req_valid = 4'b0100;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("t6 async busy", busy0, 0);
    chk("t6 async ready", rdy0, 0);
    chk("t6 async level", lvl0, 0);
    chk("t6 async wen", wen0, 0);
    tick();
    tick();
    rst = 1'b1;
    req_valid = 4'b1111;
    tick();
    chk("t6 restart busy", busy0, 1);
    chk("t6 restart gnt", gnt0, 0);
    req_valid = 4'd0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/limber_gnrl_fifo_wrarb.md
Name: limber_gnrl_fifo_wrarb

Overview:
Round-robin write arbiter that shares one limber_gnrl_fifo_syn write port between NREQ requesters using a valid/ready handshake.
- Grants one requester at a time and holds the grant for a burst of up to MAXBURST beats.
- Back-pressures on FIFO full.
- Tracks FIFO occupancy so system logic can read the fill level without extra state.
- Sits directly in front of the FIFO's din/wen/full pins. The FIFO read side remains with the consumer.

Parameters:
NREQ, 4, number of requesters; legal range 2..16.
DW, 8, data width; must match the FIFO DW.
AW, 8, FIFO address width; must match the FIFO AW. Usable capacity is 2^AW-1 entries.
MAXBURST, 4, maximum accepted beats per grant; legal range 1..255.
IDW, 2, requester index width; set to clog2(NREQ).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  NREQ  per-requester write request
req_data  input  NREQ*DW  requester i data in bits [i*DW +: DW]
req_ready  output  NREQ  per-requester accept; a beat transfers when valid&ready
fifo_din  output  DW  to FIFO din
fifo_wen  output  1  to FIFO wen
fifo_full  input  1  from FIFO full
fifo_ren  input  1  consumer read strobe, mirrored from the FIFO ren
fifo_empty  input  1  from FIFO empty
gnt_id  output  IDW  index of the current owner; valid when busy=1
busy  output  1  1 while in XFER
level  output  AW  current FIFO occupancy, range 0..2^AW-1

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ptr=0, owner=0, beat_cnt=0, level=0. Consequently req_ready=0, fifo_wen=0, busy=0, gnt_id=0, fifo_din=0.
- States: IDLE and XFER.
- IDLE:
  - If any req_valid is high, select the first set bit scanning ptr, ptr+1, …, wrapping NREQ-1 -> 0.
  - Register the selection into owner, clear beat_cnt, go to XFER.
  - req_ready is all-zero in IDLE. Grant latency is 1 cycle from valid to XFER.
- XFER:
  - req_ready[owner] = ~fifo_full; all other ready bits are 0.
  - fifo_wen = req_valid[owner] & ~fifo_full.
  - fifo_din = req_data[owner] whenever in XFER; 0 in IDLE.
  - A beat is counted when fifo_wen=1; beat_cnt increments on each beat.
- Leaving XFER -> IDLE, with ptr <= owner+1 (wrapping at NREQ-1 -> 0), occurs when either:
  - req_valid[owner]=0 in the current cycle (no beat that cycle), or
  - a beat occurs with beat_cnt == MAXBURST-1; that final beat is accepted.
- At least one IDLE cycle separates consecutive grants, including a regrant to the same requester.
- fifo_full in XFER:
  - No beat; beat_cnt holds; the grant is held indefinitely while valid stays high (no timeout).
  - A requester dropping valid during full releases the grant.
- level:
  - +1 on fifo_wen.
  - -1 on fifo_ren & ~fifo_empty.
  - Unchanged when both occur in the same cycle.
  - Never exceeds 2^AW-1 and never underflows, by construction of full/empty.
- Requests arriving mid-burst from non-owners wait. Round-robin ptr guarantees each active requester a grant within NREQ arbitration rounds.
- Reset mid-burst: returns to IDLE immediately. No partial-state retention; data already written stays in the FIFO, which the FIFO's own reset controls.

Test Plan:
1. Reset, then req_valid=4'b0001 held, FIFO empty -> IDLE 1 cycle, gnt_id=0, four beats on consecutive cycles, IDLE 1 cycle, regrant to 0; level counts 1,2,3,4.
2. req_valid=4'b1111 continuously, MAXBURST=4 -> grant order 0,1,2,3,0; each burst exactly 4 beats; gnt_id changes only after an IDLE cycle.
3. Owner 2 drops valid after 2 beats while req_valid[3]=1 -> 2 beats accepted, IDLE, next grant to 3 with ptr=3.
4. AW=2 (capacity 3), single requester, no reads -> 3 beats accepted, fifo_full=1, ready=0, grant held; one consumer read -> 4th beat accepted next cycle; level 3->2->3.
5. Simultaneous fifo_wen and fifo_ren with level=2 -> level stays 2; fifo_ren with fifo_empty=1 -> level stays 0.
6. Assert rst=0 mid-burst at beat 2 -> busy=0, req_ready=0, level=0 immediately (asynchronous); after release, arbitration restarts from ptr=0.
